// File: rtl/bit_align_ctrl.sv
// Bit-slip alignment controller: sweeps the slipper through every slip value
// until framing words repeat on schedule, then tracks lock and counts lock losses.
module bit_align_ctrl #(
  parameter int                  DataBits    = 32,
  parameter int                  MaxSlip     = 7,
  parameter logic [DataBits-1:0] SyncPattern = 32'hF628_F628,
  parameter logic [DataBits-1:0] SyncMask    = '1,
  parameter int                  FrameWords  = 8,
  parameter int                  LockCount   = 3,
  parameter int                  UnlockCount = 2,
  parameter int                  SettleWords = 2,
  localparam int                 SlipBits    = $clog2(MaxSlip + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                restart,
  input  logic                mon_xfer,
  input  logic [DataBits-1:0] mon_data,
  output logic [SlipBits-1:0] slip_amount,
  output logic                locked,
  output logic                sweep_fail,
  output logic [7:0]          lock_loss_cnt
);

  localparam int SetW  = $clog2(SettleWords + 1);
  localparam int FrmW  = $clog2(FrameWords);
  localparam int GoodW = $clog2(LockCount + 1);
  localparam int MissW = $clog2(UnlockCount + 1);

  localparam logic [SetW-1:0]     SETTLE_LAST = SetW'(SettleWords - 1);
  localparam logic [FrmW-1:0]     FRAME_LAST  = FrmW'(FrameWords - 1);
  localparam logic [GoodW-1:0]    GOOD_LAST   = GoodW'(LockCount - 1);
  localparam logic [MissW-1:0]    MISS_LAST   = MissW'(UnlockCount - 1);
  localparam logic [SlipBits-1:0] SLIP_MAX    = SlipBits'(MaxSlip);

  typedef enum logic [2:0] {IDLE, SETTLE, SEARCH, VERIFY, LOCKED} state_t;

  state_t               state;
  logic [SetW-1:0]      settle_cnt;
  logic [FrmW-1:0]      frame_cnt;
  logic [GoodW-1:0]     good_cnt;
  logic [MissW-1:0]     miss_cnt;
  logic [SlipBits-1:0]  sweep_cnt;
  logic                 match;
  logic                 do_slip;

  assign match = ((mon_data ^ SyncPattern) & SyncMask) == '0;

  // SEARCH timing out and VERIFY missing its slot reduce to the same condition:
  // the FrameWords-th counted word arrives without a match.
  assign do_slip = mon_xfer && !match && (frame_cnt == FRAME_LAST) &&
                   ((state == SEARCH) || (state == VERIFY));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      slip_amount   <= '0;
      locked        <= 1'b0;
      sweep_fail    <= 1'b0;
      lock_loss_cnt <= '0;
      settle_cnt    <= '0;
      frame_cnt     <= '0;
      good_cnt      <= '0;
      miss_cnt      <= '0;
      sweep_cnt     <= '0;
    end else if (!enable) begin
      state      <= IDLE;
      locked     <= 1'b0;
      settle_cnt <= '0;
      frame_cnt  <= '0;
      good_cnt   <= '0;
      miss_cnt   <= '0;
      sweep_cnt  <= '0;
    end else if (restart) begin
      state       <= SETTLE;
      slip_amount <= '0;
      locked      <= 1'b0;
      sweep_fail  <= 1'b0;
      settle_cnt  <= '0;
      frame_cnt   <= '0;
      good_cnt    <= '0;
      miss_cnt    <= '0;
      sweep_cnt   <= '0;
    end else if (do_slip) begin
      state       <= SETTLE;
      locked      <= 1'b0;
      settle_cnt  <= '0;
      frame_cnt   <= '0;
      good_cnt    <= '0;
      slip_amount <= (slip_amount == SLIP_MAX) ? '0 : slip_amount + 1'b1;
      if (sweep_cnt == SLIP_MAX) begin
        sweep_fail <= 1'b1;
        sweep_cnt  <= '0;
      end else begin
        sweep_cnt <= sweep_cnt + 1'b1;
      end
    end else begin
      case (state)
        IDLE: begin
          state      <= SETTLE;
          settle_cnt <= '0;
        end
        SETTLE: begin
          if (mon_xfer) begin
            if (settle_cnt == SETTLE_LAST) begin
              state     <= SEARCH;
              frame_cnt <= '0;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
        end
        SEARCH: begin
          if (mon_xfer) begin
            if (match) begin
              frame_cnt <= '0;
              if (LockCount == 1) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                miss_cnt <= '0;
              end else begin
                state    <= VERIFY;
                good_cnt <= GoodW'(1);
              end
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        VERIFY: begin
          if (mon_xfer) begin
            if (frame_cnt == FRAME_LAST) begin
              frame_cnt <= '0;
              if (good_cnt == GOOD_LAST) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                good_cnt <= '0;
                miss_cnt <= '0;
              end else begin
                good_cnt <= good_cnt + 1'b1;
              end
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        LOCKED: begin
          if (mon_xfer) begin
            if (frame_cnt == FRAME_LAST) begin
              frame_cnt <= '0;
              if (match) begin
                miss_cnt <= '0;
              end else if (miss_cnt == MISS_LAST) begin
                state     <= SEARCH;
                locked    <= 1'b0;
                miss_cnt  <= '0;
                sweep_cnt <= '0;
                if (lock_loss_cnt != 8'hFF) lock_loss_cnt <= lock_loss_cnt + 1'b1;
              end else begin
                miss_cnt <= miss_cnt + 1'b1;
              end
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_align_ctrl.sv
// Directed bench for bit_align_ctrl at default parameters: lock acquisition,
// slip sweep, sweep failure, lock loss, restart, enable and reset behaviour.
module tb_bit_align_ctrl;

  localparam logic [31:0] SYNC  = 32'hF628_F628;
  localparam logic [31:0] NOISE = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        restart = 1'b0;
  logic        mon_xfer = 1'b0;
  logic [31:0] mon_data = '0;
  logic [2:0]  slip_amount;
  logic        locked;
  logic        sweep_fail;
  logic [7:0]  lock_loss_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  bit_align_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .restart       (restart),
    .mon_xfer      (mon_xfer),
    .mon_data      (mon_data),
    .slip_amount   (slip_amount),
    .locked        (locked),
    .sweep_fail    (sweep_fail),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 clk = ~clk;

  // One transferred word; outputs are observed 1 time unit after the edge.
  task automatic xfer(input logic [31:0] d);
    @(negedge clk);
    mon_xfer = 1'b1;
    mon_data = d;
    @(posedge clk);
    #1;
    mon_xfer = 1'b0;
  endtask

  task automatic noise_words(input int n);
    for (int i = 0; i < n; i++) xfer(NOISE);
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (slip_amount !== 3'd0) $display("FAIL reset_slip: got %0d want 0", slip_amount); else pass_cnt++;
    total_cnt++; if (locked !== 1'b0) $display("FAIL reset_locked: got %0b want 0", locked); else pass_cnt++;
    total_cnt++; if (sweep_fail !== 1'b0) $display("FAIL reset_sweep_fail: got %0b want 0", sweep_fail); else pass_cnt++;
    total_cnt++; if (lock_loss_cnt !== 8'd0) $display("FAIL reset_loss_cnt: got %0d want 0", lock_loss_cnt); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Two settle words, non-transferred sync-looking cycles, then syncs every 8 words.
  task automatic test_aligned();
    noise_words(2);
    @(negedge clk);
    mon_data = SYNC;
    repeat (3) @(negedge clk);
    xfer(SYNC);
    noise_words(7);
    xfer(SYNC);
    total_cnt++; if (locked !== 1'b0) $display("FAIL aligned_early: got %0b want 0", locked); else pass_cnt++;
    noise_words(7);
    xfer(SYNC);
    total_cnt++; if (locked !== 1'b1) $display("FAIL aligned_lock: got %0b want 1", locked); else pass_cnt++;
    total_cnt++; if (slip_amount !== 3'd0) $display("FAIL aligned_slip: got %0d want 0", slip_amount); else pass_cnt++;
  endtask

  task automatic test_lock_loss();
    noise_words(8);
    total_cnt++; if (locked !== 1'b1) $display("FAIL loss_one_miss: got %0b want 1", locked); else pass_cnt++;
    noise_words(7);
    xfer(SYNC);
    total_cnt++; if (locked !== 1'b1) $display("FAIL loss_recover: got %0b want 1", locked); else pass_cnt++;
    noise_words(8);
    total_cnt++; if (locked !== 1'b1) $display("FAIL loss_first_miss: got %0b want 1", locked); else pass_cnt++;
    noise_words(8);
    total_cnt++; if (locked !== 1'b0) $display("FAIL loss_unlock: got %0b want 0", locked); else pass_cnt++;
    total_cnt++; if (lock_loss_cnt !== 8'd1) $display("FAIL loss_count: got %0d want 1", lock_loss_cnt); else pass_cnt++;
    total_cnt++; if (slip_amount !== 3'd0) $display("FAIL loss_slip: got %0d want 0", slip_amount); else pass_cnt++;
  endtask

  // Continues in SEARCH after lock loss: two good syncs, then a corrupted slot.
  task automatic test_verify_corrupt();
    xfer(SYNC);
    noise_words(7);
    xfer(SYNC);
    noise_words(7);
    xfer(SYNC ^ 32'h0000_0100);
    total_cnt++; if (slip_amount !== 3'd1) $display("FAIL verify_slip: got %0d want 1", slip_amount); else pass_cnt++;
    total_cnt++; if (locked !== 1'b0) $display("FAIL verify_locked: got %0b want 0", locked); else pass_cnt++;
  endtask

  // Slips 0..4 carry no sync: each step costs 2 settle + 8 search words.
  task automatic test_slip5();
    pulse_restart();
    total_cnt++; if (slip_amount !== 3'd0) $display("FAIL slip5_restart: got %0d want 0", slip_amount); else pass_cnt++;
    for (int w = 1; w <= 50; w++) begin
      xfer(NOISE);
      if (w % 10 == 0) begin
        total_cnt++;
        if (slip_amount !== 3'(w / 10)) $display("FAIL slip5_step%0d: got %0d want %0d", w, slip_amount, w / 10);
        else pass_cnt++;
      end
      if (w == 49) begin
        total_cnt++;
        if (slip_amount !== 3'd4) $display("FAIL slip5_hold: got %0d want 4", slip_amount); else pass_cnt++;
      end
    end
    noise_words(2);
    xfer(SYNC);
    noise_words(7);
    xfer(SYNC);
    noise_words(7);
    xfer(SYNC);
    total_cnt++; if (locked !== 1'b1) $display("FAIL slip5_lock: got %0b want 1", locked); else pass_cnt++;
    total_cnt++; if (slip_amount !== 3'd5) $display("FAIL slip5_final: got %0d want 5", slip_amount); else pass_cnt++;
    total_cnt++; if (sweep_fail !== 1'b0) $display("FAIL slip5_sweep: got %0b want 0", sweep_fail); else pass_cnt++;
  endtask

  task automatic test_sweep_fail();
    pulse_restart();
    noise_words(70);
    total_cnt++; if (slip_amount !== 3'd7) $display("FAIL sweep_slip7: got %0d want 7", slip_amount); else pass_cnt++;
    noise_words(9);
    total_cnt++; if (sweep_fail !== 1'b0) $display("FAIL sweep_early: got %0b want 0", sweep_fail); else pass_cnt++;
    noise_words(1);
    total_cnt++; if (slip_amount !== 3'd0) $display("FAIL sweep_wrap: got %0d want 0", slip_amount); else pass_cnt++;
    total_cnt++; if (sweep_fail !== 1'b1) $display("FAIL sweep_flag: got %0b want 1", sweep_fail); else pass_cnt++;
    noise_words(10);
    total_cnt++; if (slip_amount !== 3'd1) $display("FAIL sweep_continue: got %0d want 1", slip_amount); else pass_cnt++;
    pulse_restart();
    total_cnt++; if (slip_amount !== 3'd0) $display("FAIL sweep_restart_slip: got %0d want 0", slip_amount); else pass_cnt++;
    total_cnt++; if (sweep_fail !== 1'b0) $display("FAIL sweep_restart_flag: got %0b want 0", sweep_fail); else pass_cnt++;
  endtask

  task automatic test_reset_locked();
    pulse_restart();
    noise_words(32);
    xfer(SYNC);
    noise_words(7);
    xfer(SYNC);
    noise_words(7);
    xfer(SYNC);
    total_cnt++; if (locked !== 1'b1) $display("FAIL rstlock_pre_lock: got %0b want 1", locked); else pass_cnt++;
    total_cnt++; if (slip_amount !== 3'd3) $display("FAIL rstlock_pre_slip: got %0d want 3", slip_amount); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    total_cnt++; if (slip_amount !== 3'd0) $display("FAIL rstlock_slip: got %0d want 0", slip_amount); else pass_cnt++;
    total_cnt++; if (locked !== 1'b0) $display("FAIL rstlock_locked: got %0b want 0", locked); else pass_cnt++;
    total_cnt++; if (lock_loss_cnt !== 8'd0) $display("FAIL rstlock_loss: got %0d want 0", lock_loss_cnt); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    noise_words(10);
    total_cnt++; if (slip_amount !== 3'd1) $display("FAIL post_reset_slip: got %0d want 1", slip_amount); else pass_cnt++;
    @(negedge clk);
    enable = 1'b0;
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
    total_cnt++; if (slip_amount !== 3'd1) $display("FAIL disable_restart_slip: got %0d want 1", slip_amount); else pass_cnt++;
    noise_words(12);
    total_cnt++; if (slip_amount !== 3'd1) $display("FAIL disable_idle_slip: got %0d want 1", slip_amount); else pass_cnt++;
    total_cnt++; if (locked !== 1'b0) $display("FAIL disable_locked: got %0b want 0", locked); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_lock_loss();
    test_verify_corrupt();
    test_slip5();
    test_sweep_fail();
    test_reset_locked();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
